exc_pipe_chain: RTL

Parametrised exception-record pipeline: a chain of `STAGES` registers that carries branch-delay flag, victim PC, ExcCode, a valid bit and a generic payload from the fetch boundary down to the stage where the CP0 handles exceptions. It generalises the single exception-record stage register with these additions:
- per-stage exception merging that preserves the earliest cause;
- a movable stall boundary that inserts a bubble behind the frozen stages;
- pipeline-wide redirect on exception entry (`Req`) and on `ERET`.

---
 rtl/exc_pipe_chain.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/exc_pipe_chain.sv
// Exception-record pipeline: STAGES registers that carry BD/VPC/ExcCode/payload from fetch to CP0.
// The earliest cause is kept, a stall boundary can move, and Req/ERET flush and redirect the chain.

module exc_stage #(
  parameter int          PAY_W   = 32,
  parameter int          EXC_W   = 5,
  parameter logic [31:0] PC_INIT = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             flush,
  input  logic [31:0]      flush_vpc,
  input  logic             hold,
  input  logic             bubble,
  input  logic             src_valid,
  input  logic             src_bd,
  input  logic [31:0]      src_vpc,
  input  logic [EXC_W-1:0] src_exc,
  input  logic [PAY_W-1:0] src_pay,
  input  logic [EXC_W-1:0] x_exc,
  output logic             valid,
  output logic             bd,
  output logic [31:0]      vpc,
  output logic [EXC_W-1:0] exc,
  output logic [PAY_W-1:0] pay
);
  logic [EXC_W-1:0] merged;

  // A carried code always wins; bubbles never pick one up.
  assign merged = (src_valid && src_exc == '0) ? x_exc : src_exc;

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      valid <= 1'b0; bd <= 1'b0; vpc <= PC_INIT;   exc <= '0; pay <= '0;
    end else if (flush) begin
      valid <= 1'b0; bd <= 1'b0; vpc <= flush_vpc; exc <= '0; pay <= '0;
    end else if (bubble) begin
      // Bubble keeps BD/VPC of the stalled record so EPC still names it.
      valid <= 1'b0; bd <= src_bd; vpc <= src_vpc; exc <= '0; pay <= '0;
    end else if (!hold) begin
      valid <= src_valid; bd <= src_bd; vpc <= src_vpc; exc <= merged; pay <= src_pay;
    end
  end
endmodule

module exc_pipe_chain #(
  parameter int          STAGES       = 3,
  parameter int          PAY_W        = 32,
  parameter int          EXC_W        = 5,
  parameter logic [31:0] PC_INIT      = 32'h0000_3000,
  parameter logic [31:0] HANDLE_START = 32'h0000_4180,
  localparam int         SW           = $clog2(STAGES)
) (
  input  logic                        clk,
  input  logic                        RESET_N,
  input  logic                        Req,
  input  logic                        ERET,
  input  logic [31:0]                 EPC,
  input  logic                        STALL_N,
  input  logic [SW-1:0]               STALL_AT,
  input  logic                        D_VALID,
  input  logic                        D_BD,
  input  logic [31:0]                 D_VPC,
  input  logic [EXC_W-1:0]            D_ExcCode,
  input  logic [PAY_W-1:0]            D_PAY,
  input  logic [(STAGES-1)*EXC_W-1:0] X_ExcCode,
  output logic [STAGES-1:0]           Q_VALID,
  output logic [STAGES-1:0]           Q_BD,
  output logic [STAGES*32-1:0]        Q_VPC,
  output logic [STAGES*EXC_W-1:0]     Q_ExcCode,
  output logic [STAGES*PAY_W-1:0]     Q_PAY,
  output logic                        EXC_PENDING
);
  logic [SW-1:0]                  k;
  logic [31:0]                    k32;
  logic                           flush;
  logic [31:0]                    flush_vpc;
  logic [STAGES-1:0]              hold, bubble, valid, bd;
  logic [STAGES-1:0][31:0]        vpc;
  logic [STAGES-1:0][EXC_W-1:0]   exc;
  logic [STAGES-1:0][PAY_W-1:0]   pay;

  // Out-of-range boundary saturates to the last stage: full freeze, no bubble.
  assign k         = (32'(STALL_AT) > 32'(STAGES-1)) ? SW'(STAGES-1) : STALL_AT;
  assign k32       = 32'(k);
  assign flush     = Req || ERET;
  assign flush_vpc = Req ? HANDLE_START : EPC;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             src_valid, src_bd;
    logic [31:0]      src_vpc;
    logic [EXC_W-1:0] src_exc, x_exc;
    logic [PAY_W-1:0] src_pay;

    if (i == 0) begin : g_head
      assign src_valid = D_VALID;
      assign src_bd    = D_BD;
      assign src_vpc   = D_VPC;
      assign src_exc   = D_ExcCode;
      assign src_pay   = D_PAY;
      assign x_exc     = '0;
    end else begin : g_body
      assign src_valid = valid[i-1];
      assign src_bd    = bd[i-1];
      assign src_vpc   = vpc[i-1];
      assign src_exc   = exc[i-1];
      assign src_pay   = pay[i-1];
      assign x_exc     = X_ExcCode[(i-1)*EXC_W +: EXC_W];
    end

    assign hold[i]   = !STALL_N && (32'(i) <= k32);
    assign bubble[i] = !STALL_N && (32'(i) == k32 + 32'd1);

    exc_stage #(.PAY_W(PAY_W), .EXC_W(EXC_W), .PC_INIT(PC_INIT)) u_stage (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .flush     (flush),
      .flush_vpc (flush_vpc),
      .hold      (hold[i]),
      .bubble    (bubble[i]),
      .src_valid (src_valid),
      .src_bd    (src_bd),
      .src_vpc   (src_vpc),
      .src_exc   (src_exc),
      .src_pay   (src_pay),
      .x_exc     (x_exc),
      .valid     (valid[i]),
      .bd        (bd[i]),
      .vpc       (vpc[i]),
      .exc       (exc[i]),
      .pay       (pay[i])
    );
  end

  assign Q_VALID     = valid;
  assign Q_BD        = bd;
  assign Q_VPC       = vpc;
  assign Q_ExcCode   = exc;
  assign Q_PAY       = pay;
  assign EXC_PENDING = valid[STAGES-1] && (exc[STAGES-1] != '0);
endmodule
